sipo_deserializer: RTL and testbench

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

---
 rtl/sipo_deserializer.sv | 67 ++++++
 tb/tb_sipo_deserializer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in parallel-out word assembler with a one-word output register,
// sticky overrun/frame error flags and configurable bit order.
module sipo_deserializer #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bit_in,
    input  logic         bit_valid,
    input  logic         frame_start,
    input  logic         out_ready,
    input  logic         clear_err,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    output logic         busy,
    output logic         overrun,
    output logic         frame_err
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_next;
    logic [N-1:0]  shreg_q, shreg_d, data_q, data_d, shifted, first;
    logic          valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
    logic          accept, done, free;
    always_comb begin
        shifted  = MSB_FIRST ? {shreg_q[N-2:0], bit_in} : {bit_in, shreg_q[N-1:1]};
        first    = MSB_FIRST ? {{(N-1){1'b0}}, bit_in} : {bit_in, {(N-1){1'b0}}};
        accept   = bit_valid && (frame_start || state_q == SHIFT);
        cnt_next = frame_start ? CW'(1) : cnt_q + CW'(1);
        done     = accept && cnt_next == CW'(N);
        free     = !valid_q || out_ready;
        state_d  = accept ? (done ? IDLE : SHIFT) : state_q;
        cnt_d    = accept ? (done ? '0 : cnt_next) : cnt_q;
        shreg_d  = accept ? (frame_start ? first : shifted) : shreg_q;
        data_d   = (done && free) ? shifted : data_q;
        valid_d  = (done && free) || (valid_q && !out_ready);
        // a pending set beats a simultaneous clear_err
        ovr_d    = (done && !free) || (ovr_q && !clear_err);
        ferr_d   = (bit_valid && frame_start && state_q == SHIFT) || (ferr_q && !clear_err);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = state_q == SHIFT;
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: drives an MSB-first and an LSB-first instance with the same inputs
// and compares both against a frame-level model built from bit queues.
module tb_sipo_deserializer;
    localparam int N = 8;
    logic clk = 1'b0;
    logic reset = 1'b1, bit_in = 1'b0, bit_valid = 1'b0, frame_start = 1'b0;
    logic out_ready = 1'b0, clear_err = 1'b0;
    logic [N-1:0] data_m, data_l;
    logic valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l, ferr_m, ferr_l;
    int checks = 0, failures = 0;
    bit fq[$];
    bit in_frame = 0, m_v = 0, m_ovr = 0, m_ferr = 0;
    logic [N-1:0] m_dm = '0, m_dl = '0;

    sipo_deserializer #(.N(N), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .out_ready(out_ready), .clear_err(clear_err),
        .out_data(data_m), .out_valid(valid_m), .busy(busy_m), .overrun(ovr_m), .frame_err(ferr_m));
    sipo_deserializer #(.N(N), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .out_ready(out_ready), .clear_err(clear_err),
        .out_data(data_l), .out_valid(valid_l), .busy(busy_l), .overrun(ovr_l), .frame_err(ferr_l));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Frame-level reference: collect the bits of the current frame, form the word when N arrive.
    task automatic model();
        bit done = 0, set_ovr = 0, set_ferr = 0;
        logic [N-1:0] wm = '0, wl = '0;
        if (reset) begin
            fq.delete(); in_frame = 0; m_v = 0; m_ovr = 0; m_ferr = 0; m_dm = '0; m_dl = '0;
            return;
        end
        if (bit_valid && frame_start) begin
            set_ferr = in_frame;
            fq.delete(); fq.push_back(bit_in); in_frame = 1;
        end else if (bit_valid && in_frame) fq.push_back(bit_in);
        if (in_frame && fq.size() == N) begin
            for (int i = 0; i < N; i++) begin
                wm[N-1-i] = fq[i];
                wl[i] = fq[i];
            end
            done = 1; in_frame = 0; fq.delete();
        end
        if (done && (!m_v || out_ready)) begin
            m_v = 1; m_dm = wm; m_dl = wl;
        end else if (done) set_ovr = 1;
        else if (m_v && out_ready) m_v = 0;
        m_ovr  = set_ovr || (m_ovr && !clear_err);
        m_ferr = set_ferr || (m_ferr && !clear_err);
    endtask

    task automatic step();
        @(posedge clk);
        model();
        #1;
        chk("data_msb", 32'(data_m), 32'(m_dm));
        chk("data_lsb", 32'(data_l), 32'(m_dl));
        chk("valid", {valid_m, valid_l}, {m_v, m_v});
        chk("busy", {busy_m, busy_l}, {in_frame, in_frame});
        chk("overrun", {ovr_m, ovr_l}, {m_ovr, m_ovr});
        chk("frame_err", {ferr_m, ferr_l}, {m_ferr, m_ferr});
    endtask

    // Sends w[7], w[6], ... with optional random gaps; gap cycles toggle unqualified frame_start.
    task automatic send(input logic [7:0] w, input int nbits, input bit fs, input int maxgap, input bit rdy_last);
        for (int i = 0; i < nbits; i++) begin
            int g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                bit_valid = 0; frame_start = 1'($urandom); bit_in = 1'($urandom);
                step();
                if (fs && i > 0) chk("busy_in_gap", busy_l, 1);
            end
            bit_valid = 1; bit_in = w[7-i]; frame_start = fs && i == 0;
            if (rdy_last && i == nbits - 1) out_ready = 1;
            step();
            bit_valid = 0; frame_start = 0;
        end
    endtask

    initial begin
        step(); step();
        chk("reset_outputs", {data_m, valid_m, busy_m, ovr_m, ferr_m}, '0);
        reset = 0; out_ready = 1;
        send(8'hA5, 8, 1, 0, 0);
        chk("a5_msb", data_m, 8'hA5);
        chk("a5_valid", valid_m, 1);
        send(8'hA5, 8, 1, 3, 0);
        chk("a5_lsb_gaps", data_l, 8'hA5);
        step();
        out_ready = 0;
        send(8'h3C, 8, 1, 0, 0);
        send(8'hFF, 8, 1, 1, 0);
        chk("overrun_hold", data_m, 8'h3C);
        chk("overrun_set", ovr_m, 1);
        clear_err = 1; step(); clear_err = 0;
        chk("overrun_clear", ovr_m, 0);
        send(8'h5A, 8, 1, 0, 1);
        chk("replace_data", data_m, 8'h5A);
        chk("replace_valid", valid_m, 1);
        chk("replace_ovr", ovr_m, 0);
        step();
        chk("consumed", valid_m, 0);
        send(8'hF0, 5, 1, 0, 0);
        send(8'h81, 8, 1, 0, 0);
        chk("ferr_set", ferr_m, 1);
        chk("ferr_data", data_m, 8'h81);
        step();
        send(8'hC3, 4, 1, 0, 0);
        reset = 1; step(); reset = 0;
        send(8'hFF, 4, 0, 0, 0);
        chk("reset_midframe", {data_m, data_l, valid_m, valid_l, busy_m, ovr_m, ferr_m}, '0);
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(63, 0) == 0);
            bit_valid = 1'($urandom); bit_in = 1'($urandom);
            frame_start = ($urandom_range(11, 0) == 0);
            out_ready = 1'($urandom);
            clear_err = ($urandom_range(15, 0) == 0);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
